// File: rtl/jacobi_2d_addr_gen.sv
// jacobi_2d_addr_gen
// Loop-nest address generator for the jacobi-2d stencil. Walks every interior
// point (i, j in 1..n-2) of an n x n grid for tsteps time steps, feeds row and
// stride into an external 3-stage ce-gated multiplier, and re-joins the column
// index with the product to emit a flat address row*stride + col.
//
// Handshake: out_valid/out_ready. A beat transfers on a rising edge where both
// are high. Once out_valid is high, out_* stay stable until the beat transfers.
// The single pipeline enable en = !out_valid || out_ready freezes this block's
// pipeline and the multiplier (through mul_ce) together, so the column, row and
// last delay lines stay aligned with mul_p.
//
// dbg_state exposes the FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE).
module jacobi_2d_addr_gen #(
   parameter int ROW_W    = 10,
   parameter int STRIDE_W = 11,
   parameter int ADDR_W   = 20,
   parameter int MUL_LAT  = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ROW_W-1:0]    cfg_n,
   input  logic [STRIDE_W-1:0] cfg_stride,
   input  logic [7:0]          cfg_tsteps,
   output logic                busy,
   output logic                done,
   output logic [ROW_W-1:0]    mul_a,
   output logic [STRIDE_W-1:0] mul_b,
   output logic                mul_ce,
   input  logic [ADDR_W-1:0]   mul_p,
   output logic [ADDR_W-1:0]   out_addr,
   output logic [ROW_W-1:0]    out_i,
   output logic [ROW_W-1:0]    out_j,
   output logic                out_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ROW_W-1:0] ONE_R   = ROW_W'(1);
   localparam logic [ROW_W-1:0] TWO_R   = ROW_W'(2);
   localparam logic [ROW_W-1:0] THREE_R = ROW_W'(3);

   // FSM and loop-counter state
   state_t              r_state;
   logic                r_busy;
   logic                r_done;
   logic [ROW_W-1:0]    r_n_m2;
   logic [STRIDE_W-1:0] r_stride;
   logic [7:0]          r_ts_m1;
   logic [7:0]          r_t;
   logic [ROW_W-1:0]    r_i;
   logic [ROW_W-1:0]    r_j;

   // Issue stage: operand registers plus the head of the delay lines
   logic [ROW_W-1:0]    r_mul_a;
   logic [STRIDE_W-1:0] r_mul_b;
   logic                r_iss_v;
   logic [ROW_W-1:0]    r_iss_i;
   logic [ROW_W-1:0]    r_iss_j;
   logic                r_iss_last;

   // Delay lines running beside the multiplier stages
   logic [MUL_LAT:1]    r_dv;
   logic [MUL_LAT:1]    r_dl;
   logic [ROW_W-1:0]    r_di [1:MUL_LAT];
   logic [ROW_W-1:0]    r_dj [1:MUL_LAT];

   // Output register
   logic                r_out_valid;
   logic [ADDR_W-1:0]   r_out_addr;
   logic [ROW_W-1:0]    r_out_i;
   logic [ROW_W-1:0]    r_out_j;
   logic                r_out_last;

   logic                w_en;
   logic                w_idle;
   logic                w_degenerate;
   logic                w_issue;
   logic                w_accept_last;
   logic [7:0]          w_cur_t;
   logic [ROW_W-1:0]    w_cur_i;
   logic [ROW_W-1:0]    w_cur_j;
   logic [ROW_W-1:0]    w_nm2;
   logic [7:0]          w_tsm1;
   logic [STRIDE_W-1:0] w_stride;
   logic                w_j_wrap;
   logic                w_i_wrap;
   logic                w_cur_last;

   assign w_en          = !r_out_valid || out_ready;
   assign w_idle        = (r_state == S_IDLE);
   assign w_degenerate  = (cfg_n < THREE_R) || (cfg_tsteps == 8'd0);
   assign w_accept_last = r_out_valid && out_ready && r_out_last;

   // In IDLE the point about to be issued is (0,1,1) against the live config,
   // so the first point goes out on the same edge that accepts start.
   assign w_cur_t  = w_idle ? 8'd0 : r_t;
   assign w_cur_i  = w_idle ? ONE_R : r_i;
   assign w_cur_j  = w_idle ? ONE_R : r_j;
   assign w_nm2    = w_idle ? (cfg_n - TWO_R) : r_n_m2;
   assign w_tsm1   = w_idle ? (cfg_tsteps - 8'd1) : r_ts_m1;
   assign w_stride = w_idle ? cfg_stride : r_stride;

   assign w_j_wrap   = (w_cur_j == w_nm2);
   assign w_i_wrap   = (w_cur_i == w_nm2);
   assign w_cur_last = (w_cur_t == w_tsm1) && w_i_wrap && w_j_wrap;

   assign w_issue = (w_idle && start && !w_degenerate) ||
                    ((r_state == S_RUN) && w_en);

   // Control FSM: config latch, loop counters and the issue stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_n_m2     <= '0;
         r_stride   <= '0;
         r_ts_m1    <= '0;
         r_t        <= '0;
         r_i        <= '0;
         r_j        <= '0;
         r_mul_a    <= '0;
         r_mul_b    <= '0;
         r_iss_v    <= 1'b0;
         r_iss_i    <= '0;
         r_iss_j    <= '0;
         r_iss_last <= 1'b0;
      end else begin
         if (w_issue) begin
            r_mul_a    <= w_cur_i;
            r_mul_b    <= w_stride;
            r_iss_v    <= 1'b1;
            r_iss_i    <= w_cur_i;
            r_iss_j    <= w_cur_j;
            r_iss_last <= w_cur_last;
            if (w_j_wrap) begin
               r_j <= ONE_R;
               if (w_i_wrap) begin
                  r_i <= ONE_R;
                  r_t <= w_cur_t + 8'd1;
               end else begin
                  r_i <= w_cur_i + ONE_R;
                  r_t <= w_cur_t;
               end
            end else begin
               r_j <= w_cur_j + ONE_R;
               r_i <= w_cur_i;
               r_t <= w_cur_t;
            end
         end else if (w_en) begin
            // Nothing to issue: push a bubble into the pipeline
            r_iss_v    <= 1'b0;
            r_iss_last <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_busy   <= 1'b1;
                  r_n_m2   <= cfg_n - TWO_R;
                  r_stride <= cfg_stride;
                  r_ts_m1  <= cfg_tsteps - 8'd1;
                  if (w_degenerate) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else if (w_cur_last) begin
                     // n = 3 with one time step: the only point is also the last
                     r_state <= S_DRAIN;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (w_en && w_cur_last) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_accept_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Delay lines and output register, all frozen together when en is low
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dv        <= '0;
         r_dl        <= '0;
         for (int k = 1; k <= MUL_LAT; k++) begin
            r_di[k] <= '0;
            r_dj[k] <= '0;
         end
         r_out_valid <= 1'b0;
         r_out_addr  <= '0;
         r_out_i     <= '0;
         r_out_j     <= '0;
         r_out_last  <= 1'b0;
      end else if (w_en) begin
         r_dv[1] <= r_iss_v;
         r_dl[1] <= r_iss_last;
         r_di[1] <= r_iss_i;
         r_dj[1] <= r_iss_j;
         for (int k = 2; k <= MUL_LAT; k++) begin
            r_dv[k] <= r_dv[k-1];
            r_dl[k] <= r_dl[k-1];
            r_di[k] <= r_di[k-1];
            r_dj[k] <= r_dj[k-1];
         end
         // Stage MUL_LAT lines up with mul_p; the add wraps modulo 2^ADDR_W
         r_out_valid <= r_dv[MUL_LAT];
         r_out_addr  <= mul_p + ADDR_W'(r_dj[MUL_LAT]);
         r_out_i     <= r_di[MUL_LAT];
         r_out_j     <= r_dj[MUL_LAT];
         r_out_last  <= r_dl[MUL_LAT];
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign mul_a     = r_mul_a;
   assign mul_b     = r_mul_b;
   assign mul_ce    = w_en;
   assign out_addr  = r_out_addr;
   assign out_i     = r_out_i;
   assign out_j     = r_out_j;
   assign out_last  = r_out_last;
   assign out_valid = r_out_valid;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_jacobi_2d_addr_gen.sv
// Bench for jacobi_2d_addr_gen: clock/reset, a 3-stage ce-gated multiplier
// model, directed and randomized runs, and a negedge scoreboard fed by a
// loop-nest reference model.
module tb_jacobi_2d_addr_gen;
  localparam int ROW_W    = 10;
  localparam int STRIDE_W = 11;
  localparam int ADDR_W   = 20;
  localparam int EW       = ADDR_W + 2 * ROW_W + 1;  // {addr, i, j, last}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                start = 1'b0;
  logic [ROW_W-1:0]    cfg_n = '0;
  logic [STRIDE_W-1:0] cfg_stride = '0;
  logic [7:0]          cfg_tsteps = '0;
  logic                busy, done, mul_ce, out_last, out_valid;
  logic                out_ready = 1'b1;
  logic [ROW_W-1:0]    mul_a, out_i, out_j;
  logic [STRIDE_W-1:0] mul_b;
  logic [ADDR_W-1:0]   mul_p, out_addr;
  logic [1:0]          dbg_state;

  jacobi_2d_addr_gen dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_n(cfg_n), .cfg_stride(cfg_stride), .cfg_tsteps(cfg_tsteps),
    .busy(busy), .done(done),
    .mul_a(mul_a), .mul_b(mul_b), .mul_ce(mul_ce), .mul_p(mul_p),
    .out_addr(out_addr), .out_i(out_i), .out_j(out_j),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .dbg_state(dbg_state)
  );

  // Multiplier: three ce-gated stages, product truncated to ADDR_W.
  // mul_bias lifts products near 2^20 so the address wrap is reachable
  // without a million-beat run; the model adds the same bias.
  logic [ADDR_W-1:0] m1 = '0, m2 = '0, m3 = '0;
  int mul_bias = 0;
  always @(posedge clk) begin
    if (mul_ce) begin
      m1 <= ADDR_W'(32'(mul_a) * 32'(mul_b) + 32'(mul_bias));
      m2 <= m1;
      m3 <= m2;
    end
  end
  assign mul_p = m3;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int model_addr(input int i, input int s, input int j, input int bias);
    return (i * s + bias + j) % (1 << ADDR_W);
  endfunction

  // Reference: every (t, i, j) interior point in loop order, capped in length.
  function automatic void build_model(input int n, input int s, input int t,
                                      input int bias, input int cap);
    logic [EW-1:0] e;
    exp_q.delete();
    if (n < 3 || t == 0) return;
    for (int tt = 0; tt < t; tt++)
      for (int ii = 1; ii <= n - 2; ii++)
        for (int jj = 1; jj <= n - 2; jj++) begin
          if (exp_q.size() >= cap) return;
          e = {ADDR_W'(model_addr(ii, s, jj, bias)), ROW_W'(ii), ROW_W'(jj),
               (tt == t - 1 && ii == n - 2 && jj == n - 2) ? 1'b1 : 1'b0};
          exp_q.push_back(e);
        end
  endfunction

  int done_cnt = 0;
  int done_cyc = 0;
  int first_v_cyc = -1;
  logic prev_stall = 1'b0;
  logic [41:0] prev_out = '0;

  // Compare process: sampled on the falling edge, every cycle out of reset
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      chk("mul_ce_equals_en", mul_ce, (!out_valid || out_ready) ? 1 : 0);
      if (prev_stall)
        chk("held_while_stalled", {out_valid, out_addr, out_i, out_j, out_last}, prev_out);
      if (out_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", out_addr, e[EW-1 -: ADDR_W]);
          chk("beat_i", out_i, e[2*ROW_W:ROW_W+1]);
          chk("beat_j", out_j, e[ROW_W:1]);
          chk("beat_last", out_last, e[0]);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_after_all_beats", exp_q.size(), 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, out_addr, out_i, out_j, out_last};
    end
  end

  // ---------------- drivers ----------------
  int ready_mode = 0;  // 0: always ready, 1: random, 2: low in cycles 6..8 of a run
  int s_cyc = -100;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = ($urandom_range(0, 99) < 70);
        2:       out_ready = !((cyc - s_cyc) >= 6 && (cyc - s_cyc) <= 8);
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic pulse_start(input int n, input int s, input int t);
    @(posedge clk);
    #1;
    cfg_n      = ROW_W'(n);
    cfg_stride = STRIDE_W'(s);
    cfg_tsteps = 8'(t);
    start      = 1'b1;
    s_cyc      = cyc;
    first_v_cyc = -1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Later config changes must not affect the run in flight
    cfg_n      = ROW_W'($urandom_range(0, 1023));
    cfg_stride = STRIDE_W'($urandom_range(0, 2047));
    cfg_tsteps = 8'($urandom_range(0, 255));
  endtask

  // One complete run; returns done and first-valid cycles relative to start.
  task automatic run(input int n, input int s, input int t, input int bias,
                     input bit poke, output int done_rel, output int fv_rel);
    int dc0;
    int k;
    build_model(n, s, t, bias, 1 << 30);
    mul_bias = bias;
    dc0 = done_cnt;
    pulse_start(n, s, t);
    chk("busy_after_start", busy, 1);
    k = 0;
    while (done_cnt == dc0 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
      if (poke && k == 2 && busy) begin
        cfg_n = ROW_W'($urandom_range(3, 9));
        cfg_stride = STRIDE_W'($urandom_range(0, 2047));
        cfg_tsteps = 8'($urandom_range(1, 4));
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_within_budget", done_cnt - dc0, 1);
    done_rel = done_cyc - s_cyc;
    fv_rel   = (first_v_cyc < 0) ? -1 : first_v_cyc - s_cyc;
    chk("busy_low_after_done", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("single_done_pulse", done_cnt - dc0, 1);
    chk("idle_out_valid_low", out_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_out_ij"}, {out_i, out_j}, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_mul_ab"}, {mul_a, mul_b}, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d, f, dc0, k;
    logic [EW-1:0] e;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Pin the model with hand-computed values
    build_model(4, 4, 1, 0, 100);
    chk("model_len_n4", exp_q.size(), 4);
    e = exp_q[0];
    chk("model_first_addr", e[EW-1 -: ADDR_W], 5);
    e = exp_q[2];
    chk("model_third_addr", e[EW-1 -: ADDR_W], 9);
    chk("model_third_last", e[0], 0);
    e = exp_q[3];
    chk("model_last_addr", e[EW-1 -: ADDR_W], 10);
    chk("model_last_flag", e[0], 1);
    // 998*2047 + 998 = 2,043,904, which wraps to 995,328
    chk("model_addr_998_998", model_addr(998, 2047, 998, 0), 995328);
    chk("model_wrap_addr", model_addr(1, 2047, 3, (1 << 20) - 2050), 0);
    exp_q.delete();

    // Basic run
    run(4, 4, 1, 0, 1'b0, d, f);
    chk("t1_first_valid_cycle", f, 5);
    chk("t1_done_cycle", d, 9);

    // Two time steps, with a start pulse mid-run that must be ignored
    run(4, 4, 2, 0, 1'b1, d, f);
    chk("t2_first_valid_cycle", f, 5);
    chk("t2_done_cycle", d, 13);

    // Backpressure in cycles 6..8
    ready_mode = 2;
    run(4, 4, 1, 0, 1'b0, d, f);
    chk("t3_first_valid_cycle", f, 5);
    chk("t3_done_cycle", d, 12);
    ready_mode = 0;

    // Degenerate configurations
    run(2, 5, 3, 0, 1'b0, d, f);
    chk("t4_n2_done_cycle", d, 1);
    chk("t4_n2_no_valid", f, -1);
    run(6, 5, 0, 0, 1'b0, d, f);
    chk("t4_ts0_done_cycle", d, 1);
    chk("t4_ts0_no_valid", f, -1);

    // Smallest real grid: a single interior point per step
    run(3, 7, 1, 0, 1'b0, d, f);
    chk("n3_done_cycle", d, 6);

    // Full-width run: first two rows of n=1000, stride=2047, then abort
    build_model(1000, 2047, 1, 0, 2 * 998);
    e = exp_q[997];
    chk("model_row1_end", e[EW-1 -: ADDR_W], 3045);
    e = exp_q[998];
    chk("model_row2_start", e[EW-1 -: ADDR_W], 4095);
    mul_bias = 0;
    dc0 = done_cnt;
    pulse_start(1000, 2047, 1);
    k = 0;
    while (exp_q.size() > 0 && k < 2200) begin
      @(posedge clk);
      #1;
      k++;
    end
    reset = 1'b1;
    chk("wide_rows_consumed", exp_q.size(), 0);
    #1;
    check_reset_outputs("abort_wide");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    chk("abort_wide_no_done", done_cnt - dc0, 0);

    // Address wrap modulo 2^20 in the column add
    run(6, 2047, 1, (1 << 20) - 2050, 1'b0, d, f);
    chk("wrap_done_cycle", d, 5 + 16);

    // Reset during RUN, then a clean rerun of the basic case
    build_model(4, 4, 1, 0, 100);
    mul_bias = 0;
    dc0 = done_cnt;
    pulse_start(4, 4, 1);
    while (cyc - s_cyc < 6) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    check_reset_outputs("abort_run");
    repeat (3) @(posedge clk);
    #1;
    chk("abort_run_no_done", done_cnt - dc0, 0);
    reset = 1'b0;
    exp_q.delete();
    run(4, 4, 1, 0, 1'b0, d, f);
    chk("t6_first_valid_cycle", f, 5);
    chk("t6_done_cycle", d, 9);

    // Randomized runs with random backpressure
    ready_mode = 1;
    for (int r = 0; r < 12; r++) begin
      run($urandom_range(2, 8), $urandom_range(0, 2047), $urandom_range(0, 3),
          ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, (1 << 20) - 1)) : 0,
          1'(($urandom_range(0, 1))), d, f);
    end
    ready_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
